// File: rtl/keypad_scan_ctrl.sv
// Column-scanning sequencer for the 4x4 PMOD keypad.
// Emits debounced single-key events with a hex code.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       ghost
);

  typedef enum logic [1:0] {
    IDLE, DRIVE, SAMPLE, EVAL
  } state_t;

  typedef enum logic [1:0] {
    C_NONE, C_SINGLE, C_MULTI
  } cls_t;

  localparam logic [15:0] SETTLE_LAST =
    16'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  // Nibble i holds the code for sweep bit i = col*4+row
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  state_t      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] sweep_q, sweep_d;
  cls_t        pcls_q, pcls_d;
  logic [3:0]  pcode_q, pcode_d;
  logic [3:0]  deb_q, deb_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic        ghost_q, ghost_d;
  logic [3:0]  row_s1, row_s2;

  cls_t        cls;
  logic [3:0]  code;
  logic [4:0]  ones;
  logic [3:0]  idx;
  logic        match;
  logic        accept;
  logic [3:0]  deb_next;

  always_comb begin
    ones = 5'd0;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (sweep_q[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    cls  = C_NONE;
    code = 4'h0;
    if (ones == 5'd1) begin
      cls  = C_SINGLE;
      code = KEY_MAP[{idx, 2'b00} +: 4];
    end else if (ones != 5'd0) begin
      cls = C_MULTI;
    end
  end

  always_comb begin
    match = (deb_q != 4'd0) && (cls == pcls_q)
         && (code == pcode_q);
    if (!match)
      deb_next = 4'd1;
    else if (deb_q == 4'hF)
      deb_next = 4'hF;
    else
      deb_next = deb_q + 4'd1;
    accept = (deb_next == DEB)
          && (!match || deb_q < DEB);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    sweep_d = sweep_q;
    pcls_d  = pcls_q;
    pcode_d = pcode_q;
    deb_d   = deb_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    ghost_d = ghost_q;
    if (state_q != IDLE && !scan_en) begin
      state_d = IDLE;
      col_d   = 2'd0;
      cnt_d   = 16'd0;
      sweep_d = 16'd0;
      pcls_d  = C_NONE;
      pcode_d = 4'h0;
      deb_d   = 4'd0;
      held_d  = 1'b0;
      ghost_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (scan_en) begin
            state_d = DRIVE;
            col_d   = 2'd0;
            cnt_d   = 16'd0;
          end
        end
        DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = SAMPLE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        SAMPLE: begin
          sweep_d[{col_q, 2'b00} +: 4] = ~row_s2;
          if (col_q == 2'd3) begin
            state_d = EVAL;
          end else begin
            col_d   = col_q + 2'd1;
            state_d = DRIVE;
          end
        end
        EVAL: begin
          state_d = DRIVE;
          col_d   = 2'd0;
          sweep_d = 16'd0;
          pcls_d  = cls;
          pcode_d = code;
          deb_d   = deb_next;
          if (accept) begin
            if (cls == C_SINGLE) begin
              if (!held_q || code != code_q) begin
                code_d  = code;
                valid_d = 1'b1;
              end
              held_d  = 1'b1;
              ghost_d = 1'b0;
            end else if (cls == C_MULTI) begin
              held_d  = 1'b0;
              ghost_d = 1'b1;
            end else begin
              held_d  = 1'b0;
              ghost_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      cnt_q   <= 16'd0;
      sweep_q <= 16'd0;
      pcls_q  <= C_NONE;
      pcode_q <= 4'h0;
      deb_q   <= 4'd0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      ghost_q <= 1'b0;
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      sweep_q <= sweep_d;
      pcls_q  <= pcls_d;
      pcode_q <= pcode_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      ghost_q <= ghost_d;
      row_s1  <= row_in;
      row_s2  <= row_s1;
    end
  end

  assign col_out = (state_q == DRIVE || state_q == SAMPLE)
                 ? ~(4'b0001 << col_q) : 4'b1111;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign ghost     = ghost_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a simple
// keypad model (pressed bit = col*4+row).
module tb_keypad_scan_ctrl;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        ghost;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int consec = 0;
  logic kv_prev = 1'b0;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .ghost(ghost)
  );

  always #5 clock = ~clock;

  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && keys[c*4+r])
          row_in[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (key_valid) begin
      pulses++;
      if (kv_prev) consec++;
    end
    kv_prev = key_valid;
  end

  typedef struct {
    logic [15:0] keys;
    int          sweeps;
    int          npulse;
    logic        kv;
    logic [3:0]  code;
    logic        held;
    logic        ghost;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] want);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (col_out != want && n < 200);
    if (col_out != want) begin
      checks++;
      errors++;
      $display("FAIL wait_col: got %b expected %b",
               col_out, want);
    end
  endtask

  initial begin
    int p0;
    logic [3:0] exp_col;

    vecs[0]  = '{16'h0000,  1, 0, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0040,  2, 1, 1'b1, 4'h8, 1'b1, 1'b0};
    vecs[2]  = '{16'h0040, 10, 0, 1'b0, 4'h8, 1'b1, 1'b0};
    vecs[3]  = '{16'h0000,  1, 0, 1'b0, 4'h8, 1'b1, 1'b0};
    vecs[4]  = '{16'h0000,  1, 0, 1'b0, 4'h8, 1'b0, 1'b0};
    vecs[5]  = '{16'h0040,  2, 1, 1'b1, 4'h8, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000,  2, 1, 1'b1, 4'hD, 1'b1, 1'b0};
    vecs[7]  = '{16'h0001,  1, 0, 1'b0, 4'hD, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000,  1, 0, 1'b0, 4'hD, 1'b1, 1'b0};
    vecs[9]  = '{16'h0001,  1, 0, 1'b0, 4'hD, 1'b1, 1'b0};
    vecs[10] = '{16'h0000,  1, 0, 1'b0, 4'hD, 1'b1, 1'b0};
    vecs[11] = '{16'h0001,  2, 1, 1'b1, 4'h1, 1'b1, 1'b0};
    vecs[12] = '{16'h0021,  2, 0, 1'b0, 4'h1, 1'b0, 1'b1};
    vecs[13] = '{16'h0001,  2, 1, 1'b1, 4'h1, 1'b1, 1'b0};
    vecs[14] = '{16'h0001,  1, 0, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[15] = '{16'h0008,  2, 1, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[16] = '{16'h0080,  2, 1, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[17] = '{16'h0800,  2, 1, 1'b1, 4'hE, 1'b1, 1'b0};
    vecs[18] = '{16'h1000,  2, 1, 1'b1, 4'hA, 1'b1, 1'b0};
    vecs[19] = '{16'h0200,  2, 1, 1'b1, 4'h6, 1'b1, 1'b0};

    repeat (3) @(negedge clock);
    check("rst_col", 16'(col_out), 16'hF);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    check("rst_ghost", 16'(ghost), 16'h0);

    rst_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 21; i++) begin
      exp_col = (i == 20) ? 4'b1111
              : ~(4'b0001 << (i / 5));
      check($sformatf("seq%0d_col", i),
            16'(col_out), 16'(exp_col));
      if (i < 20) @(negedge clock);
    end
    @(negedge clock);
    #1;

    for (int i = 0; i < 20; i++) begin
      keys = vecs[i].keys;
      p0 = pulses;
      for (int s = 0; s < vecs[i].sweeps; s++)
        wait_col(4'b1111);
      @(negedge clock);
      #1;
      check($sformatf("v%0d_pulses", i),
            16'(pulses - p0), 16'(vecs[i].npulse));
      check($sformatf("v%0d_valid", i),
            16'(key_valid), 16'(vecs[i].kv));
      check($sformatf("v%0d_code", i),
            16'(key_code), 16'(vecs[i].code));
      check($sformatf("v%0d_held", i),
            16'(key_held), 16'(vecs[i].held));
      check($sformatf("v%0d_ghost", i),
            16'(ghost), 16'(vecs[i].ghost));
    end

    // drop scan_en during column 2 drive, '6' still held
    wait_col(4'b1011);
    @(negedge clock);
    scan_en = 1'b0;
    p0 = pulses;
    @(negedge clock);
    check("dis_col", 16'(col_out), 16'hF);
    check("dis_held", 16'(key_held), 16'h0);
    check("dis_ghost", 16'(ghost), 16'h0);
    check("dis_code", 16'(key_code), 16'h6);
    repeat (30) @(negedge clock);
    check("dis_idle_col", 16'(col_out), 16'hF);
    check("dis_pulses", 16'(pulses - p0), 16'h0);
    scan_en = 1'b1;
    @(negedge clock);
    check("reen_col0", 16'(col_out), 16'hE);
    wait_col(4'b1111);
    wait_col(4'b1111);
    @(negedge clock);
    #1;
    check("reen_pulses", 16'(pulses - p0), 16'h1);
    check("reen_valid", 16'(key_valid), 16'h1);
    check("reen_code", 16'(key_code), 16'h6);
    check("reen_held", 16'(key_held), 16'h1);

    // async reset during column 0 sample cycle
    repeat (4) @(negedge clock);
    check("samp_col", 16'(col_out), 16'hE);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_col", 16'(col_out), 16'hF);
    check("ar_code", 16'(key_code), 16'h0);
    check("ar_held", 16'(key_held), 16'h0);
    check("ar_valid", 16'(key_valid), 16'h0);
    repeat (3) @(negedge clock);
    keys = 16'h0000;
    p0 = pulses;
    rst_n = 1'b1;
    repeat (30) @(negedge clock);
    check("ar_rel_pulses", 16'(pulses - p0), 16'h0);
    check("ar_rel_code", 16'(key_code), 16'h0);
    check("consec_valid", 16'(consec), 16'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
